// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler.
package rf_wb_sched_pkg;

    localparam int unsigned N_REGS   = 16;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned XLEN     = 32;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    typedef struct packed {
        logic            valid;
        reg_id_t         rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } rr_side_t;

    // Ids outside the implemented file alias to x0.
    function automatic logic id_live(input reg_id_t id);
        return (id != '0) && (int'(id) < int'(N_REGS));
    endfunction

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only advances on contention.
module rr_arb2
    import rf_wb_sched_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_side_t ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr == SIDE_A) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= SIDE_A;
        end else if (req == 2'b11) begin
            ptr <= (ptr == SIDE_A) ? SIDE_B : SIDE_A;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Arbitrates ALU/load writebacks onto the single RF write port and
// tracks outstanding destinations to stall issue on RAW/WAW hazards.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                iss_valid,
    input  logic [REG_ID_W-1:0] iss_rs1,
    input  logic [REG_ID_W-1:0] iss_rs2,
    input  logic [REG_ID_W-1:0] iss_rd,
    input  logic                iss_rd_wen,
    output logic                iss_stall,
    input  logic                a_valid,
    input  logic [REG_ID_W-1:0] a_rd,
    input  logic [XLEN-1:0]     a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [REG_ID_W-1:0] b_rd,
    input  logic [XLEN-1:0]     b_data,
    output logic                b_ready,
    output logic                rf_wen,
    output logic [REG_ID_W-1:0] rf_rd,
    output logic [XLEN-1:0]     rf_wdata,
    output logic [N_REGS-1:0]   pending
);

    localparam int unsigned IDX_W = $clog2(N_REGS);

    function automatic logic pend_at(input reg_id_t id, input logic [N_REGS-1:0] p);
        return id_live(id) && p[id[IDX_W-1:0]];
    endfunction

    logic [1:0]        gnt;
    wb_req_t           a_req;
    wb_req_t           b_req;
    wb_req_t           win;
    logic              issue_ok;
    logic [N_REGS-1:0] set_mask;
    logic [N_REGS-1:0] clr_mask;
    logic [N_REGS-1:0] pending_nxt;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({b_valid, a_valid}),
        .gnt     (gnt)
    );

    assign a_ready = gnt[0];
    assign b_ready = gnt[1];

    always_comb begin
        a_req     = '{valid: a_valid, rd: a_rd, data: a_data};
        b_req     = '{valid: b_valid, rd: b_rd, data: b_data};
        win       = gnt[1] ? b_req : a_req;
        win.valid = |gnt;
    end

    always_comb begin
        iss_stall = iss_valid & (pend_at(iss_rs1, pending) | pend_at(iss_rs2, pending) |
                                 (iss_rd_wen & pend_at(iss_rd, pending)));
        issue_ok  = iss_valid & ~iss_stall & iss_rd_wen & id_live(iss_rd);
    end

    // Clear comes from the registered RF stage so a dependent issue cannot
    // read the RF in the same cycle the value is still being committed.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_ok) begin
            set_mask[iss_rd[IDX_W-1:0]] = 1'b1;
        end
        if (rf_wen && id_live(rf_rd)) begin
            clr_mask[rf_rd[IDX_W-1:0]] = 1'b1;
        end
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_wen   <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (win.valid) begin
            rf_wen   <= 1'b1;
            rf_rd    <= win.rd;
            rf_wdata <= win.data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Scoreboard bench for rf_wb_sched: expected RF writes are queued at grant
// time and matched by a monitor when rf_wen appears.
module tb_rf_wb_sched;
    import rf_wb_sched_pkg::*;

    logic                clock;
    logic                reset_n;
    logic                flush;
    logic                iss_valid;
    logic [REG_ID_W-1:0] iss_rs1, iss_rs2, iss_rd;
    logic                iss_rd_wen;
    logic                iss_stall;
    logic                a_valid, b_valid;
    logic [REG_ID_W-1:0] a_rd, b_rd;
    logic [XLEN-1:0]     a_data, b_data;
    logic                a_ready, b_ready;
    logic                rf_wen;
    logic [REG_ID_W-1:0] rf_rd;
    logic [XLEN-1:0]     rf_wdata;
    logic [N_REGS-1:0]   pending;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct packed {
        logic [REG_ID_W-1:0] rd;
        logic [XLEN-1:0]     data;
    } wr_t;
    wr_t wq[$];

    rf_wb_sched dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .iss_valid  (iss_valid),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd     (iss_rd),
        .iss_rd_wen (iss_rd_wen),
        .iss_stall  (iss_stall),
        .a_valid    (a_valid),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .pending    (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every RF write must match the oldest queued grant.
    always @(negedge clock) begin
        if (reset_n && rf_wen) begin
            wr_t e;
            if (wq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rf_write_unexpected: got rd=%0d data=0x%0h expected none", rf_rd, rf_wdata);
            end else begin
                e = wq.pop_front();
                check("rf_rd", 32'(rf_rd), 32'(e.rd));
                check("rf_wdata", rf_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_rd_wen = 0;
        a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen);
        iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_rd_wen = wen;
    endtask

    // One writeback cycle: drive requests, check grants, queue the winner.
    task automatic wb(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic ea, input logic eb, input string tag);
        a_valid = av; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
        #1;
        check({tag, "_a_ready"}, 32'(a_ready), 32'(ea));
        check({tag, "_b_ready"}, 32'(b_ready), 32'(eb));
        if (ea) wq.push_back('{rd: ar, data: ad});
        else if (eb) wq.push_back('{rd: br, data: bd});
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        #1;
        check("reset_rf_wen", 32'(rf_wen), 32'd0);
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_rf_rd", 32'(rf_rd), 32'd0);
        check("reset_rf_wdata", rf_wdata, 32'd0);
        step(); step();
        reset_n = 1;

        // Idle issue with no pending registers.
        step();
        issue(5'd3, 5'd4, 5'd0, 1'b0);
        #1;
        check("idle_stall", 32'(iss_stall), 32'd0);

        // RAW hazard on x5, cleared by an ALU writeback.
        step();
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        #1;
        check("issue_rd5_stall", 32'(iss_stall), 32'd0);
        step();
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        #1;
        check("pending_rd5", 32'(pending), 32'h0020);
        check("raw_stall_N", 32'(iss_stall), 32'd1);
        wb(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 1, 0, "alu_rd5");
        step();
        a_valid = 0;
        #1;
        check("raw_stall_N1", 32'(iss_stall), 32'd1);
        check("rf_wen_N1", 32'(rf_wen), 32'd1);
        step();
        #1;
        check("pending_N2", 32'(pending), 32'h0);
        check("raw_stall_N2", 32'(iss_stall), 32'd0);
        iss_valid = 0;

        // Contention: alternate A,B,A,B.
        step(); wb(1, 5'd1, 32'hA0000001, 1, 5'd2, 32'hB0000001, 1, 0, "rr0");
        step(); wb(1, 5'd1, 32'hA0000002, 1, 5'd2, 32'hB0000001, 0, 1, "rr1");
        step(); wb(1, 5'd1, 32'hA0000002, 1, 5'd2, 32'hB0000002, 1, 0, "rr2");
        step(); wb(1, 5'd1, 32'hA0000003, 1, 5'd2, 32'hB0000002, 0, 1, "rr3");

        // Solo B grants leave the pointer on A.
        step(); wb(0, 5'd0, 32'd0, 1, 5'd3, 32'hC0000001, 0, 1, "solo0");
        step(); wb(0, 5'd0, 32'd0, 1, 5'd3, 32'hC0000002, 0, 1, "solo1");
        step(); wb(0, 5'd0, 32'd0, 1, 5'd3, 32'hC0000003, 0, 1, "solo2");
        step(); wb(1, 5'd4, 32'hA0000010, 1, 5'd3, 32'hC0000004, 1, 0, "after_solo");
        step(); wb(1, 5'd4, 32'hA0000011, 1, 5'd3, 32'hC0000004, 0, 1, "after_solo2");
        step(); a_valid = 0; b_valid = 0;

        // x0 and out-of-range ids never become pending.
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        step(); issue(5'd0, 5'd0, 5'd17, 1'b1);
        #1;
        check("pending_x0", 32'(pending), 32'h0);
        step();
        iss_valid = 0;
        #1;
        check("pending_rd17", 32'(pending), 32'h0);
        wb(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 1, 0, "wb_x0");
        step(); a_valid = 0;
        step();
        #1;
        check("pending_after_wb_x0", 32'(pending), 32'h0);

        // Flush overrides a same-cycle issue.
        issue(5'd0, 5'd0, 5'd4, 1'b1);
        step(); iss_rd = 5'd5;
        step(); iss_rd = 5'd6;
        step(); iss_rd = 5'd7;
        step();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        flush = 1;
        #1;
        check("pending_pre_flush", 32'(pending), 32'h00F0);
        check("flush_issue_stall", 32'(iss_stall), 32'd0);
        step();
        flush = 0; iss_valid = 0;
        #1;
        check("pending_flushed", 32'(pending), 32'h0);

        // Reset while a write is in flight drops it at once.
        a_valid = 1; a_rd = 5'd3; a_data = 32'h55AA55AA;
        step();
        a_valid = 0;
        #1;
        check("inflight_rf_wen", 32'(rf_wen), 32'd1);
        check("inflight_rf_rd", 32'(rf_rd), 32'd3);
        reset_n = 0;
        #1;
        check("reset_drop_rf_wen", 32'(rf_wen), 32'd0);
        step();
        reset_n = 1;
        step(); step();
        check("scoreboard_drained", 32'(wq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Shares the register file's single write port between two writeback sources: A = execute/ALU, B = load unit.
- Tracks destination registers with an outstanding write in a pending scoreboard, and stalls issue on RAW/WAW hazards.
- Sits between decode/issue, the writeback sources and the register file; drives the RF's wen/rd/wdata port directly.

Parameters:
- N_REGS, 16, architectural registers implemented (RV32E); ids >= N_REGS are treated as x0.
- REG_ID_W, 5, register id width.
- XLEN, 32, data width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  clears scoreboard (pipeline redirect)
- iss_valid  in  1  instruction at issue
- iss_rs1  in  REG_ID_W  source 1 id
- iss_rs2  in  REG_ID_W  source 2 id
- iss_rd  in  REG_ID_W  destination id
- iss_rd_wen  in  1  instruction writes rd
- iss_stall  out  1  combinational hazard stall
- a_valid  in  1  ALU writeback request
- a_rd  in  REG_ID_W  ALU destination
- a_data  in  XLEN  ALU result
- a_ready  out  1  ALU request accepted this cycle
- b_valid  in  1  load writeback request
- b_rd  in  REG_ID_W  load destination
- b_data  in  XLEN  load result
- b_ready  out  1  load request accepted this cycle
- rf_wen  out  1  registered RF write enable
- rf_rd  out  REG_ID_W  registered RF write id
- rf_wdata  out  XLEN  registered RF write data
- pending  out  N_REGS  scoreboard bitmap, bit 0 always 0

Behaviour:
- Reset (reset_n low, asynchronous): pending=0, rf_wen=0, rf_rd=0, rf_wdata=0, rr_ptr=A.
- "Live" id: an id that is nonzero and < N_REGS. All other ids behave as x0: never pending, never stall, never written.
- iss_stall = iss_valid & (pending[rs1] | pending[rs2] | (iss_rd_wen & pending[rd])), evaluated for live ids only.
- Issue accepted (iss_valid & !iss_stall & iss_rd_wen & live rd): set pending[rd] at the next edge.
- Arbitration uses a 1-bit round-robin pointer rr_ptr:
  - Only one valid: grant it.
  - Both valid: grant the side rr_ptr points to; rr_ptr then flips to the other side.
  - Single-requester grants leave rr_ptr unchanged.
- a_ready/b_ready are combinational grants. A request is consumed only when valid & ready; otherwise the source holds its request stable.
- Write latency: a grant in cycle N gives rf_wen=1 with the granted rd/data in cycle N+1. RF commits at the end of N+1.
- Pending clear: a grant to a live rd clears pending[rd] at the end of cycle N. A dependent issue therefore unstalls in N+1 and reads the RF in N+1.
  - The RF read is combinational, so a same-cycle read of the register being written would return stale data.
  - Required rule: pending clears at end of N+1, aligned with the RF commit. Implement pending clear from the registered rf_wen/rf_rd stage, not from the grant.
- Grant to a non-live rd: consumed; rf_wen=1 is still driven, and the RF ignores it. Pending is untouched.
- No grant: rf_wen=0; rf_rd and rf_wdata hold their previous values.
- Same-edge set and clear of the same id: set wins. This is unreachable under WAW stall but is still defined.
- flush: pending=0 at the next edge; this overrides any same-cycle set. Writebacks granted in the same cycle still reach the RF. rr_ptr is unchanged.
- Reset mid-operation: the in-flight rf_wen is dropped immediately; no partial write.

Decomposition:
- Shared package (soc defs): N_REGS, REG_ID_W, XLEN, typedef reg_id_t, typedef wb_req_t {valid, rd, data}.
- One sub-module: rr_arb2, a 2-way round-robin arbiter with req[1:0] in, gnt[1:0] out, 1-bit pointer state.
- The scoreboard and RF-port registers stay in rf_wb_sched.

Test Plan:
- Reset then idle: pending=0, rf_wen=0; iss_valid, rs1=3, rs2=4 -> iss_stall=0.
- Issue rd=5 (wen) -> pending=0x0020. Next cycle issue rs1=5 -> iss_stall=1. a_valid, a_rd=5, a_data=0xDEADBEEF in cycle N -> a_ready=1; rf_wen/rf_rd=5/0xDEADBEEF in N+1; pending[5]=0 in N+2; iss_stall=0 in N+2.
- a_valid and b_valid held for 4 cycles with rd=1/2 -> grants A,B,A,B; rf_rd sequence 1,2,1,2.
- Only b_valid for 3 cycles, then both valid -> B,B,B, then the grant goes to whichever side rr_ptr points to (A after reset); rr_ptr is unchanged by the solo grants.
- Issue rd=0 and rd=17 with wen -> pending stays 0; a writeback to rd=0 is accepted with pending unchanged.
- pending=0x00F0 with flush asserted alongside an accepted issue rd=9 -> pending=0 next cycle. Assert reset_n=0 while rf_wen=1 -> rf_wen=0 immediately.
